fcims_order_ctrl: RTL and testbench
===================================

Name: fcims_order_ctrl

Overview:
Sequential controller for the food-court inventory datapath. It owns the registered stock count, unit price and running total, and arbitrates two counter terminals (requesters) with round-robin priority. Each granted order runs the stock check, the qty×price multiply and the total accumulate as one serialized transaction, then answers the requester with a one-cycle ack and accept/reject status.

Parameters:
INIT_STOCK, 0, stock value loaded on reset (4-bit, 0..15)
INIT_PRICE, 0, unit price loaded on reset (4-bit, 0..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  one clock; reset is asynchronous and active-low
cfg_we  in  1  load cfg_price/cfg_stock; honoured only in IDLE
cfg_price  in  4  new unit price
cfg_stock  in  4  new stock count
req0, req1  in  1  order request from terminal 0/1; held until ack
qty0, qty1  in  4  order quantity, stable while req high
op0, op1  in  1  0 = sell (subtract stock, charge), 1 = restock (add stock, no charge)
ack0, ack1  out  1  one-cycle completion pulse to the terminal
ok  out  1  1 = accepted, 0 = rejected; valid only while an ack is high
fprice  out  8  price of the last completed transaction
stock  out  4  current stock
tprice  out  8  running total price
empty  out  1  stock == 0
busy  out  1  FSM not in IDLE
tovf  out  1  sticky: tprice wrapped past 255

Behaviour:
- Reset (reset=0, async): state=IDLE, stock=INIT_STOCK, price=INIT_PRICE, tprice=0, fprice=0, ack0=ack1=ok=tovf=0, rr pointer=0 (terminal 0 has priority first). Any in-flight order is discarded with no ack.
- FSM: IDLE -> EXEC -> RESP -> IDLE. All outputs are registered.
- IDLE: if cfg_we=1, load price and stock and stay in IDLE. cfg has priority over req in the same cycle. Else if any req is high, grant it. If both are high, grant the terminal that is not the rr pointer's last grant. Latch id/qty/op, then go to EXEC. Otherwise stay.
- EXEC, sell: if qty > stock, reject with no state change and fprice=0. Else stock -= qty, fprice = qty*price (full 8-bit product, max 225), and tprice = (tprice + fprice) mod 256. Set tovf if the add carries out.
- EXEC, restock: if stock + qty > 15, reject with no change. Else stock += qty. fprice=0; tprice is unchanged.
- qty=0 is always accepted and changes nothing except fprice=0.
- RESP: ack[id]=1 for exactly this cycle, ok=result. The rr pointer records id. Next state is IDLE. ack and ok return to 0 in the following cycle.
- Latency: req sampled in IDLE at edge N gives ack high during cycle N+2. Throughput is one order per 3 cycles.
- Requester protocol: hold req, qty and op until ack is seen; drop req at the edge after ack. Dropping req early does not cancel the latched order, which still completes and acks. If req is still high in the IDLE cycle after ack, it is treated as a new order.
- cfg_we while busy is ignored (not queued).
- empty and stock update in the same cycle as the commit (visible in RESP). tovf clears only on reset.

Test Plan:
- Reset with INIT_STOCK=10, INIT_PRICE=3 -> stock=10, tprice=0, empty=0, busy=0, acks=0. Assert reset mid-EXEC -> no ack; registers return to init values.
- req0 sell qty=4 -> ack0 at cycle N+2 with ok=1, fprice=12, stock=6, tprice=12. Then req1 sell qty=7 -> ok=0, stock=6, tprice=12, fprice=0.
- req0 and req1 raised in the same cycle from reset -> terminal 0 acked first. Both then re-request -> terminal 1 acked, then terminal 0: strict alternation.
- Restock stock=12 qty=3 -> ok=1, stock=15. Restock qty=1 -> ok=0, stock=15. Sell qty=15 -> ok=1, stock=0, empty=1.
- cfg_we with price=15, stock=15, plus tprice preloaded near wrap via repeated sells (tprice=240) -> sell qty=2 gives fprice=30, tprice=14, tovf=1 (sticky through later orders).
- cfg_we and req0 asserted in the same IDLE cycle -> config loads, order granted the next cycle. cfg_we during EXEC -> ignored, price unchanged.

Source files
------------

// File: rtl/fcims_order_ctrl.sv
// Order controller for the food-court inventory datapath: owns stock, price and
// running total, and serves two terminals one serialized transaction at a time.
module fcims_order_ctrl #(
  parameter logic [3:0] INIT_STOCK = 4'd0,
  parameter logic [3:0] INIT_PRICE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_we,
  input  logic [3:0] cfg_price,
  input  logic [3:0] cfg_stock,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] qty0,
  input  logic [3:0] qty1,
  input  logic       op0,
  input  logic       op1,
  output logic       ack0,
  output logic       ack1,
  output logic       ok,
  output logic [7:0] fprice,
  output logic [3:0] stock,
  output logic [7:0] tprice,
  output logic       empty,
  output logic       busy,
  output logic       tovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t     state, state_nx;
  logic [3:0] price, price_nx, stock_nx, qty, qty_nx;
  logic       id, id_nx, op, op_nx, prio, prio_nx;
  logic       ack0_nx, ack1_nx, ok_nx, tovf_nx;
  logic [7:0] fprice_nx, tprice_nx, product;
  logic [8:0] total_sum;
  logic [4:0] restock_sum;
  logic       grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!cfg_we && (req0 || req1)) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // prio names the terminal that wins a tie; it flips away from each acked terminal
  assign grant       = (req0 && req1) ? prio : req1;
  assign product     = {4'd0, qty} * {4'd0, price};
  assign total_sum   = {1'b0, tprice} + {1'b0, product};
  assign restock_sum = {1'b0, stock} + {1'b0, qty};

  always_comb begin
    price_nx  = price;
    stock_nx  = stock;
    qty_nx    = qty;
    id_nx     = id;
    op_nx     = op;
    prio_nx   = prio;
    fprice_nx = fprice;
    tprice_nx = tprice;
    tovf_nx   = tovf;
    ack0_nx   = 1'b0;
    ack1_nx   = 1'b0;
    ok_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_we) begin
          price_nx = cfg_price;
          stock_nx = cfg_stock;
        end else if (req0 || req1) begin
          id_nx  = grant;
          qty_nx = grant ? qty1 : qty0;
          op_nx  = grant ? op1 : op0;
        end
      end
      EXEC: begin
        ack0_nx   = ~id;
        ack1_nx   = id;
        fprice_nx = 8'd0;
        if (op) begin
          if (!restock_sum[4]) begin
            stock_nx = restock_sum[3:0];
            ok_nx    = 1'b1;
          end
        end else if (qty <= stock) begin
          stock_nx  = stock - qty;
          fprice_nx = product;
          tprice_nx = total_sum[7:0];
          tovf_nx   = tovf | total_sum[8];
          ok_nx     = 1'b1;
        end
      end
      RESP:    prio_nx = ~id;
      default: ;
    endcase
  end

  // every output is a flop; empty and busy are precomputed from next-state values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      price  <= INIT_PRICE;
      stock  <= INIT_STOCK;
      qty    <= 4'd0;
      id     <= 1'b0;
      op     <= 1'b0;
      prio   <= 1'b0;
      fprice <= 8'd0;
      tprice <= 8'd0;
      tovf   <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      ok     <= 1'b0;
      empty  <= (INIT_STOCK == 4'd0);
      busy   <= 1'b0;
    end else begin
      price  <= price_nx;
      stock  <= stock_nx;
      qty    <= qty_nx;
      id     <= id_nx;
      op     <= op_nx;
      prio   <= prio_nx;
      fprice <= fprice_nx;
      tprice <= tprice_nx;
      tovf   <= tovf_nx;
      ack0   <= ack0_nx;
      ack1   <= ack1_nx;
      ok     <= ok_nx;
      empty  <= (stock_nx == 4'd0);
      busy   <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_fcims_order_ctrl.sv
// Bench for fcims_order_ctrl: transaction-level model of the order rules,
// compared against the DUT on every falling clock edge.
module tb_fcims_order_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_price = 4'd0, cfg_stock = 4'd0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] qty0 = 4'd0, qty1 = 4'd0;
  logic       op0 = 1'b0, op1 = 1'b0;
  logic       ack0, ack1, ok, empty, busy, tovf;
  logic [7:0] fprice, tprice;
  logic [3:0] stock;

  int checks = 0;
  int errors = 0;

  int m_stock, m_price, m_tprice, m_fprice, m_prio;
  bit m_tovf, last_ok;
  bit exp_ack0, exp_ack1, exp_ok, exp_busy;
  bit chk_en = 1'b0;
  bit cfg_in_exec = 1'b0;
  int rereq_left = 0;
  int grants[$];

  fcims_order_ctrl #(.INIT_STOCK(4'd10), .INIT_PRICE(4'd3)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_price(cfg_price),
    .cfg_stock(cfg_stock), .req0(req0), .req1(req1), .qty0(qty0),
    .qty1(qty1), .op0(op0), .op1(op1), .ack0(ack0), .ack1(ack1), .ok(ok),
    .fprice(fprice), .stock(stock), .tprice(tprice), .empty(empty),
    .busy(busy), .tovf(tovf)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check_output("ack0", int'(ack0), int'(exp_ack0));
      check_output("ack1", int'(ack1), int'(exp_ack1));
      check_output("ok", int'(ok), int'(exp_ok));
      check_output("busy", int'(busy), int'(exp_busy));
      check_output("stock", int'(stock), m_stock);
      check_output("empty", int'(empty), int'(m_stock == 0));
      check_output("fprice", int'(fprice), m_fprice);
      check_output("tprice", int'(tprice), m_tprice);
      check_output("tovf", int'(tovf), int'(m_tovf));
    end
  end

  task automatic model_reset();
    m_stock = 10; m_price = 3; m_tprice = 0; m_fprice = 0; m_prio = 0;
    m_tovf = 0; exp_ack0 = 0; exp_ack1 = 0; exp_ok = 0; exp_busy = 0;
  endtask

  task automatic model_commit(input int q, input bit o);
    if (o) begin
      m_fprice = 0;
      if (m_stock + q > 15) last_ok = 0;
      else begin m_stock += q; last_ok = 1; end
    end else if (q > m_stock) begin
      last_ok = 0; m_fprice = 0;
    end else begin
      m_stock -= q;
      m_fprice = q * m_price;
      if (m_tprice + m_fprice > 255) m_tovf = 1;
      m_tprice = (m_tprice + m_fprice) % 256;
      last_ok = 1;
    end
  endtask

  // runs orders until no request is pending; starts and ends just after a rising edge
  task automatic serve(input bit drop_early);
    int win; int q; bit o;
    while (req0 || req1) begin
      win = (req0 && req1) ? m_prio : (req1 ? 1 : 0);
      q = (win == 1) ? int'(qty1) : int'(qty0);
      o = (win == 1) ? op1 : op0;
      @(posedge clk);
      exp_busy = 1;
      #1;
      if (cfg_in_exec) begin
        cfg_we = 1; cfg_price = 4'($urandom); cfg_stock = 4'($urandom);
      end
      if (drop_early) begin
        if (win == 1) begin req1 = 0; qty1 = 4'($urandom); end
        else begin req0 = 0; qty0 = 4'($urandom); end
      end
      @(posedge clk);
      model_commit(q, o);
      exp_ok = last_ok;
      if (win == 1) exp_ack1 = 1; else exp_ack0 = 1;
      grants.push_back(win);
      #1;
      cfg_we = 0;
      @(posedge clk);
      exp_ack0 = 0; exp_ack1 = 0; exp_ok = 0; exp_busy = 0;
      m_prio = 1 - win;
      #1;
      if (rereq_left > 0) rereq_left--;
      else if (win == 1) req1 = 0;
      else req0 = 0;
    end
  endtask

  task automatic apply_stimulus(input bit r0, input bit r1, input logic [3:0] q0,
                                input bit o0, input logic [3:0] q1, input bit o1,
                                input bit drop_early);
    req0 = r0; qty0 = q0; op0 = o0;
    req1 = r1; qty1 = q1; op1 = o1;
    serve(drop_early);
  endtask

  task automatic do_cfg(input logic [3:0] p, input logic [3:0] s, input bit with_req0,
                        input logic [3:0] q, input bit o);
    cfg_we = 1; cfg_price = p; cfg_stock = s;
    if (with_req0) begin req0 = 1; qty0 = q; op0 = o; end
    @(posedge clk);
    m_price = int'(p); m_stock = int'(s);
    #1;
    cfg_we = 0;
    if (with_req0) serve(0);
  endtask

  task automatic reset_dut();
    reset = 0;
    model_reset();
    req0 = 0; req1 = 0; cfg_we = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    check_output("rst_stock", int'(stock), 10);
    check_output("rst_tprice", int'(tprice), 0);
    check_output("rst_empty", int'(empty), 0);
    check_output("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    reset = 1;
    idle_cycles(1);

    apply_stimulus(1, 0, 4'd4, 0, 4'd0, 0, 0);
    check_output("sell4_ok", int'(last_ok), 1);
    check_output("sell4_fprice", m_fprice, 12);
    check_output("sell4_stock", m_stock, 6);
    check_output("sell4_tprice", m_tprice, 12);
    apply_stimulus(0, 1, 4'd0, 0, 4'd7, 0, 0);
    check_output("sell7_ok", int'(last_ok), 0);
    check_output("sell7_stock", m_stock, 6);
    check_output("sell7_fprice", m_fprice, 0);
    check_output("sell7_tprice", m_tprice, 12);

    req0 = 1; qty0 = 4'd2; op0 = 0;
    @(posedge clk);
    exp_busy = 1;
    #1;
    reset_dut();
    idle_cycles(2);

    grants.delete();
    rereq_left = 2;
    apply_stimulus(1, 1, 4'd1, 0, 4'd1, 0, 0);
    check_output("rr_count", grants.size(), 4);
    check_output("rr_g0", grants[0], 0);
    check_output("rr_g1", grants[1], 1);
    check_output("rr_g2", grants[2], 0);
    check_output("rr_g3", grants[3], 1);
    check_output("rr_stock", m_stock, 6);

    do_cfg(4'd3, 4'd12, 0, 4'd0, 0);
    apply_stimulus(1, 0, 4'd3, 1, 4'd0, 0, 0);
    check_output("rs3_stock", m_stock, 15);
    apply_stimulus(0, 1, 4'd0, 0, 4'd1, 1, 0);
    check_output("rs1_ok", int'(last_ok), 0);
    apply_stimulus(1, 0, 4'd15, 0, 4'd0, 0, 0);
    check_output("sell15_stock", m_stock, 0);
    check_output("sell15_fprice", m_fprice, 45);

    reset_dut();
    do_cfg(4'd15, 4'd15, 1, 4'd15, 0);
    do_cfg(4'd15, 4'd15, 1, 4'd1, 0);
    check_output("pre_wrap_tprice", m_tprice, 240);
    apply_stimulus(1, 0, 4'd2, 0, 4'd0, 0, 0);
    check_output("wrap_fprice", m_fprice, 30);
    check_output("wrap_tprice", m_tprice, 14);
    check_output("wrap_tovf", int'(m_tovf), 1);
    apply_stimulus(0, 1, 4'd0, 0, 4'd1, 0, 0);
    check_output("sticky_tovf", int'(m_tovf), 1);

    do_cfg(4'd5, 4'd8, 1, 4'd2, 0);
    check_output("cfgreq_fprice", m_fprice, 10);
    cfg_in_exec = 1;
    apply_stimulus(1, 0, 4'd1, 0, 4'd0, 0, 0);
    cfg_in_exec = 0;
    apply_stimulus(1, 0, 4'd1, 0, 4'd0, 0, 0);
    check_output("cfgexec_fprice", m_fprice, 5);
    check_output("cfgexec_stock", m_stock, 4);

    for (int i = 0; i < 80; i++) begin
      int r;
      bit drop;
      r = $urandom_range(0, 9);
      drop = ($urandom_range(0, 3) == 0);
      cfg_in_exec = ($urandom_range(0, 4) == 0);
      if (r == 0)
        do_cfg(4'($urandom), 4'($urandom), 0, 4'd0, 0);
      else if (r == 1)
        do_cfg(4'($urandom), 4'($urandom), 1, 4'($urandom), 1'($urandom));
      else if (r < 4)
        apply_stimulus(1, 1, 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), drop);
      else if (r < 7)
        apply_stimulus(1, 0, 4'($urandom), 1'($urandom), 4'd0, 0, drop);
      else
        apply_stimulus(0, 1, 4'd0, 0, 4'($urandom), 1'($urandom), drop);
      cfg_in_exec = 0;
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
